// File: rtl/uofdm_dac_feeder.sv
// U-OFDM DAC feeder: buffers time-domain samples in a small FIFO and hands
// one sample to the LED-driver DAC on every rising edge of the divided sample
// clock. The divided clock is only ever sampled on clk, never used as a clock.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no frame in progress, DAC holds its last code
// S_PREFILL | collecting samples until PREFILL are stored or a frame end
// S_STREAM  | one pop per sample tick; IDLE_LEVEL emitted on underflow
module uofdm_dac_feeder #(
    parameter int              DW         = 16,
    parameter int              AW         = 4,
    parameter int              PREFILL    = 8,
    parameter logic [DW-1:0]   IDLE_LEVEL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          samp_clk,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    input  logic          clr_underflow,
    output logic [DW-1:0] dac_data,
    output logic          dac_wr,
    output logic          busy,
    output logic          underflow,
    output logic          frame_done
);

    localparam int              DEPTH     = 1 << AW;
    localparam logic [AW:0]     C_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]     C_PREFILL = (AW+1)'(PREFILL);

    typedef enum logic [1:0] {S_IDLE, S_PREFILL, S_STREAM} state_t;

    state_t          r_state;
    logic            r_s1, r_s2, r_s3;
    logic [DW:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [AW:0]     r_count, r_lastcnt;
    logic [DW-1:0]   r_dac_data;
    logic            r_dac_wr, r_frame_done, r_underflow;

    logic            w_tick, w_push, w_pop, w_head_last;
    logic [DW:0]     w_head;
    logic [AW:0]     w_lc_inc, w_lc_dec;

    assign w_tick      = r_s2 & ~r_s3;
    assign in_ready    = (r_count != C_FULL);
    assign w_push      = in_valid & in_ready;
    assign w_head      = r_mem[r_rptr];
    assign w_head_last = w_head[DW];
    assign w_pop       = w_tick & (r_state == S_STREAM) & (r_count != '0);
    assign w_lc_inc    = {{AW{1'b0}}, w_push & in_last};
    assign w_lc_dec    = {{AW{1'b0}}, w_pop & w_head_last};

    assign dac_data    = r_dac_data;
    assign dac_wr      = r_dac_wr;
    assign frame_done  = r_frame_done;
    assign underflow   = r_underflow;
    assign busy        = (r_state != S_IDLE);

    // Two-flop synchroniser plus a delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= samp_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_last, in_data};
        end
    end

    // FIFO pointers, occupancy and count of stored frame-end markers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_lastcnt <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_lastcnt <= r_lastcnt + w_lc_inc - w_lc_dec;
        end
    end

    // Sequencer with registered DAC outputs; a set of underflow beats a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_dac_data   <= IDLE_LEVEL;
            r_dac_wr     <= 1'b0;
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_dac_wr     <= 1'b0;
            r_frame_done <= 1'b0;
            if (clr_underflow) r_underflow <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if ((r_count != '0) || w_push) r_state <= S_PREFILL;
                end
                S_PREFILL: begin
                    if ((r_count >= C_PREFILL) || (r_lastcnt != '0)) r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_tick) begin
                        r_dac_wr <= 1'b1;
                        if (r_count != '0) begin
                            r_dac_data <= w_head[DW-1:0];
                            if (w_head_last) begin
                                r_frame_done <= 1'b1;
                                r_state      <= S_IDLE;
                            end
                        end else begin
                            r_dac_data  <= IDLE_LEVEL;
                            r_underflow <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uofdm_dac_feeder.sv
// Bench for uofdm_dac_feeder: a queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random frames.
module tb_uofdm_dac_feeder;
    localparam int          PREFILL    = 8;
    localparam logic [15:0] IDLE_LEVEL = 16'h0000;

    logic        clk = 1'b0, reset = 1'b0;
    logic        samp_clk, in_valid = 1'b0, in_last = 1'b0, clr_underflow = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, dac_wr, busy, underflow, frame_done;
    logic [15:0] dac_data;

    int n_checks = 0, n_fail = 0;

    uofdm_dac_feeder #(.DW(16), .AW(4), .PREFILL(PREFILL), .IDLE_LEVEL(IDLE_LEVEL)) dut (
        .clk(clk), .reset(reset), .samp_clk(samp_clk), .in_data(in_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .clr_underflow(clr_underflow), .dac_data(dac_data), .dac_wr(dac_wr),
        .busy(busy), .underflow(underflow), .frame_done(frame_done));

    always #5 clk = ~clk;

    // divided sample clock: div clk periods per cycle, or static man_level when div==0
    int   div = 0, gcnt = 0;
    logic man_level = 1'b0, gen_clk = 1'b0;
    assign samp_clk = (div != 0) ? gen_clk : man_level;
    always @(negedge clk) begin
        if (div != 0) begin
            gcnt    = (gcnt + 1 >= div) ? 0 : gcnt + 1;
            gen_clk = (gcnt < div / 2);
        end else begin
            gcnt    = 0;
            gen_clk = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model state
    logic [16:0] mq[$];
    int          mode;            // 0 idle, 1 prefill, 2 stream
    logic        m1, m2, m3;
    logic [15:0] e_data;
    logic        e_wr, e_fd, e_uf;
    // log of DAC writes {frame_done, data}
    logic [16:0] wdata[$];
    int          wcyc[$];
    int          cyc = 0, fd_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            mq.delete();
            mode = 0; m1 = 0; m2 = 0; m3 = 0;
            e_data = IDLE_LEVEL; e_wr = 0; e_fd = 0; e_uf = 0;
        end else begin
            bit          tick, push;
            int          lc;
            logic [16:0] e;
            tick = m2 && !m3;
            push = in_valid && (mq.size() < 16);
            lc = 0;
            foreach (mq[i]) if (mq[i][16]) lc++;
            e_wr = 0; e_fd = 0;
            if (clr_underflow) e_uf = 0;
            case (mode)
                0: if (mq.size() > 0 || push) mode = 1;
                1: if (mq.size() >= PREFILL || lc > 0) mode = 2;
                default: if (tick) begin
                    e_wr = 1;
                    if (mq.size() > 0) begin
                        e = mq.pop_front();
                        e_data = e[15:0];
                        if (e[16]) begin e_fd = 1; mode = 0; end
                    end else begin
                        e_data = IDLE_LEVEL;
                        e_uf = 1;
                    end
                end
            endcase
            if (push) mq.push_back({in_last, in_data});
            m3 = m2; m2 = m1; m1 = samp_clk;
        end
        #1;
        if (reset) begin
            chk("dac_data", dac_data, e_data);
            chk("dac_wr", dac_wr, e_wr);
            chk("frame_done", frame_done, e_fd);
            chk("underflow", underflow, e_uf);
            chk("busy", busy, mode != 0);
            chk("in_ready", in_ready, mq.size() != 16);
            if (dac_wr) begin
                wdata.push_back({frame_done, dac_data});
                wcyc.push_back(cyc);
                if (frame_done) fd_cnt++;
            end
        end
    end

    task automatic push_frame(input int n, input logic [15:0] base, input bit with_last,
                              input int maxgap, input bit rnd);
        for (int i = 0; i < n; i++) begin
            int gap, g;
            gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            repeat (gap) begin @(negedge clk); in_valid = 1'b0; end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = rnd ? 16'($urandom) : base + 16'(i);
            in_last  = with_last && (i == n - 1);
            g = 0;
            while (!in_ready && g < 3000) begin @(negedge clk); g++; end
            if (g >= 3000) begin
                n_checks++; n_fail++;
                $display("FAIL push_timeout: in_ready stuck low at %0t", $time);
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_fd(input int target);
        int g = 0;
        while (fd_cnt < target && g < 5000) begin @(negedge clk); g++; end
        chk("frame_done_wait", fd_cnt >= target, 1);
    endtask

    task automatic wait_writes(input int target);
        int g = 0;
        while (wdata.size() < target && g < 5000) begin @(negedge clk); g++; end
        chk("dac_wr_wait", wdata.size() >= target, 1);
    endtask

    initial begin
        int b, n, n2, extra, tgt;
        // reset state
        #1;
        chk("rst_dac_data", dac_data, 16'h0);
        chk("rst_dac_wr", dac_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // 1: steady stream, 20 samples 1..20, tick every 8 clk
        div = 8;
        b = wdata.size();
        push_frame(20, 16'd1, 1, 0, 0);
        wait_fd(1);
        chk("t1_count", wdata.size() - b, 20);
        for (int i = 0; i < 20; i++) chk("t1_data", wdata[b+i][15:0], i + 1);
        for (int i = 1; i < 20; i++) chk("t1_spacing", wcyc[b+i] - wcyc[b+i-1], 8);
        chk("t1_fd_on_20", wdata[b+19][16], 1);
        chk("t1_fd_not_19", wdata[b+18][16], 0);
        chk("t1_underflow", underflow, 0);

        // 2: short frame A,B,C
        b = wdata.size();
        push_frame(3, 16'hA0, 1, 0, 0);
        wait_fd(2);
        repeat (40) @(negedge clk);
        chk("t2_count", wdata.size() - b, 3);
        for (int i = 0; i < 3; i++) chk("t2_data", wdata[b+i][15:0], 16'hA0 + i);
        chk("t2_fd", wdata[b+2][16], 1);

        // 3: underflow, clear, then a single-sample frame
        div = 0; man_level = 1'b0;
        repeat (5) @(negedge clk);
        b = wdata.size();
        push_frame(8, 16'h300, 0, 0, 0);
        repeat (4) @(negedge clk);
        div = 6;
        wait_writes(b + 10);
        chk("t3_uf_data9", wdata[b+8][15:0], IDLE_LEVEL);
        chk("t3_uf_data10", wdata[b+9][15:0], IDLE_LEVEL);
        @(negedge clk);
        chk("t3_uf_set", underflow, 1);
        div = 0;
        repeat (10) @(negedge clk);
        clr_underflow = 1'b1;
        @(negedge clk);
        clr_underflow = 1'b0;
        chk("t3_uf_clear", underflow, 0);
        push_frame(1, 16'h1234, 1, 0, 0);
        div = 6;
        wait_fd(3);
        chk("t3_last_data", wdata[wdata.size()-1], {1'b1, 16'h1234});

        // 4: full FIFO with static samp_clk, then one tick frees one slot
        div = 0; man_level = 1'b0;
        repeat (5) @(negedge clk);
        n = 0;
        in_valid = 1'b1; in_last = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (in_ready) n++;
            @(negedge clk);
            in_data = 16'($urandom);
        end
        chk("t4_accepts", n, 16);
        n2 = 0;
        man_level = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (in_ready) n2++;
            @(negedge clk);
            in_data = 16'($urandom);
            if (k == 4) man_level = 1'b0;
        end
        chk("t4_one_more", n2, 1);
        in_valid = 1'b0;
        div = 5;
        push_frame(1, 16'h4444, 1, 0, 0);
        wait_fd(4);

        // 5: edge latency of a single samp_clk rise
        div = 0; man_level = 1'b0;
        repeat (5) @(negedge clk);
        push_frame(8, 16'h500, 0, 0, 0);
        repeat (4) @(negedge clk);
        man_level = 1'b1;
        @(posedge clk); #2 chk("t5_edge_n", dac_wr, 0);
        @(posedge clk); #2 chk("t5_edge_n1", dac_wr, 0);
        @(posedge clk); #2 chk("t5_edge_n2", dac_wr, 1);
        chk("t5_data", dac_data, 16'h500);
        extra = 0;
        repeat (20) begin @(posedge clk); #2 extra += int'(dac_wr); end
        chk("t5_no_second", extra, 0);
        @(negedge clk);
        man_level = 1'b0;
        div = 5;
        push_frame(1, 16'h5FF, 1, 0, 0);
        wait_fd(5);

        // 6: reset mid-frame, then a fresh 8-sample frame
        div = 0; man_level = 1'b0;
        repeat (5) @(negedge clk);
        push_frame(16, 16'h600, 0, 0, 0);
        b = wdata.size();
        div = 8;
        wait_writes(b + 5);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t6_dac_data", dac_data, IDLE_LEVEL);
        chk("t6_dac_wr", dac_wr, 0);
        chk("t6_busy", busy, 0);
        chk("t6_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        b = wdata.size();
        push_frame(8, 16'h700, 1, 0, 0);
        wait_fd(6);
        chk("t6_count", wdata.size() - b, 8);
        for (int i = 0; i < 8; i++) chk("t6_data", wdata[b+i][15:0], 16'h700 + i);

        // random frames against the model
        for (int f = 0; f < 8; f++) begin
            div = $urandom_range(4, 12);
            tgt = fd_cnt + 1;
            push_frame($urandom_range(1, 30), 16'h0, 1, 3, 1);
            wait_fd(tgt);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk); clr_underflow = 1'b1;
                @(negedge clk); clr_underflow = 1'b0;
            end
            repeat (int'($urandom_range(1, 20))) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
